// File: rtl/inc_class_histogram.sv
// inc_class_histogram: classifies accumulator increments into weight bins and keeps saturating per-bin counters.
module inc_class_histogram #(
    parameter int CNT_W = 16,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             rd_req,
    input  logic [2:0]       rd_idx,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic             smp_vld_q, smp_vld_d;
    logic [31:0]      smp_q, smp_d;
    logic [31:0]      prev_q, prev_d;
    logic             prev_ok_q, prev_ok_d;
    logic [6:0]       cls_q, cls_d;
    logic             cls_vld_q, cls_vld_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             err_q, err_d;
    logic [31:0]      delta;
    logic [7:0]       hit;

    always_comb begin
        smp_vld_d = in_valid;
        smp_d = in_valid ? in_data : smp_q;
        delta = smp_q - prev_q;
        prev_d = smp_vld_q ? smp_q : prev_q;
        prev_ok_d = prev_ok_q | smp_vld_q;
        cls_vld_d = smp_vld_q & prev_ok_q;
        cls_d[0] = delta == 32'd10;
        cls_d[1] = delta == 32'd20;
        cls_d[2] = delta == 32'd30;
        cls_d[3] = delta == 32'd40;
        cls_d[4] = delta == 32'd50;
        cls_d[5] = delta == 32'd0;
        cls_d[6] = ~|cls_d[5:0];
        // Bin 7 counts every classified sample alongside its class bin
        hit = {cls_vld_q, {7{cls_vld_q}} & cls_q};
        for (int i = 0; i < 8; i++) begin
            // A read clearing a bin that is also being incremented keeps the new event
            cnt_d[i] = (CLEAR_ON_READ && rd_req && rd_idx == i[2:0]) ? {{(CNT_W-1){1'b0}}, hit[i]} :
                       (hit[i] && cnt_q[i] != MAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
        end
        rd_valid_d = rd_req;
        rd_data_d = rd_req ? cnt_q[rd_idx] : rd_data_q;
        err_d = err_q | (cls_vld_q & cls_q[6]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_vld_q  <= 1'b0;
            smp_q      <= '0;
            prev_q     <= '0;
            prev_ok_q  <= 1'b0;
            cls_q      <= '0;
            cls_vld_q  <= 1'b0;
            cnt_q      <= '{default: '0};
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            smp_vld_q  <= smp_vld_d;
            smp_q      <= smp_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            cls_q      <= cls_d;
            cls_vld_q  <= cls_vld_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;
endmodule

// File: tb/tb_inc_class_histogram.sv
// tb_inc_class_histogram: directed scoreboard bench for inc_class_histogram (main instance plus a 2-bit saturating one).
module tb_inc_class_histogram;
    logic        clk = 1'b0;
    logic        rst, in_valid, rd_req, s_valid, s_req;
    logic [31:0] in_data, s_data;
    logic [2:0]  rd_idx, s_idx;
    logic        rd_valid, s_rd_valid, err, s_err;
    logic [15:0] rd_data;
    logic [1:0]  s_rd_data;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_s [$];
    string       name_q [$];
    string       name_s [$];

    inc_class_histogram #(.CNT_W(16), .CLEAR_ON_READ(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .err(err));

    inc_class_histogram #(.CNT_W(2), .CLEAR_ON_READ(1'b0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .rd_req(s_req),
        .rd_idx(s_idx), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .err(s_err));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%0d", rd_data);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string n = name_q.pop_front();
                if ({16'b0, rd_data} !== e) begin
                    errors++;
                    $display("FAIL %s got=%0d exp=%0d", n, rd_data, e);
                end
            end
        end
        if (s_rd_valid) begin
            checks++;
            if (exp_s.size() == 0) begin
                errors++;
                $display("FAIL sat_rd_unexpected got=%0d", s_rd_data);
            end else begin
                automatic logic [31:0] e = exp_s.pop_front();
                automatic string n = name_s.pop_front();
                if ({30'b0, s_rd_data} !== e) begin
                    errors++;
                    $display("FAIL %s got=%0d exp=%0d", n, s_rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", n, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; rd_req = 1'b0; s_valid = 1'b0; s_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        in_valid = 1'b1; in_data = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic settle();
        in_valid = 1'b0; s_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd(input string n, input logic [2:0] idx, input logic [31:0] e);
        rd_req = 1'b1; rd_idx = idx;
        exp_q.push_back(e); name_q.push_back(n);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic rd_s(input string n, input logic [2:0] idx, input logic [31:0] e);
        s_req = 1'b1; s_idx = idx;
        exp_s.push_back(e); name_s.push_back(n);
        tick();
        s_req = 1'b0;
    endtask

    initial begin
        logic [31:0] legal_exp [8];
        legal_exp = '{1, 1, 1, 1, 1, 1, 0, 6};
        in_data = '0; s_data = '0; rd_idx = '0; s_idx = '0;
        do_reset();
        chk("reset_rd_valid", {31'b0, rd_valid}, 0);
        chk("reset_rd_data", {16'b0, rd_data}, 0);
        chk("reset_err", {31'b0, err}, 0);

        // Legal sequence, then destructive re-read
        foreach (legal_exp[i]) ;
        send(0); send(50); send(90); send(120); send(140); send(150); send(150);
        settle();
        for (int b = 0; b < 8; b++) rd($sformatf("legal_bin%0d", b), b[2:0], legal_exp[b]);
        for (int b = 0; b < 8; b++) rd($sformatf("reread_bin%0d", b), b[2:0], 0);
        tick();
        chk("legal_err", {31'b0, err}, 0);

        // Gaps and wrap
        do_reset();
        send(32'hFFFF_FFFA);
        tick(); tick(); tick();
        send(32'h0000_0004);
        settle();
        rd("wrap_bin0", 3'd0, 1);
        rd("wrap_bin6", 3'd6, 0);
        rd("wrap_bin7", 3'd7, 1);
        tick();

        // Illegal increment and sticky err
        do_reset();
        send(100);
        send(107);
        tick();
        chk("err_early", {31'b0, err}, 0);
        tick();
        chk("err_set", {31'b0, err}, 1);
        rd("illegal_bin6", 3'd6, 1);
        rd("illegal_bin7", 3'd7, 1);
        tick();
        chk("err_after_read", {31'b0, err}, 1);
        repeat (10) tick();
        chk("err_after_idle", {31'b0, err}, 1);
        do_reset();
        chk("err_cleared", {31'b0, err}, 0);

        // Read colliding with a stage-2 increment of the same bin
        send(0); send(10); send(20); send(30);
        settle();
        send(40);
        tick();
        rd("collide_old", 3'd0, 3);
        rd("collide_next", 3'd0, 1);
        rd("collide_bin7", 3'd7, 4);
        tick();

        // Reset mid-operation with a read pending
        do_reset();
        send(0);
        send(10);
        rst = 1'b1; rd_req = 1'b1; rd_idx = 3'd7;
        tick();
        rst = 1'b0; rd_req = 1'b0;
        tick();
        chk("rst_mid_rd_valid", {31'b0, rd_valid}, 0);
        for (int b = 0; b < 8; b++) rd($sformatf("rst_mid_bin%0d", b), b[2:0], 0);
        send(20);
        settle();
        rd("rst_prime_bin7", 3'd7, 0);
        rd("rst_prime_bin1", 3'd1, 0);
        tick();

        // Saturation on the 2-bit, non-destructive instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_data = 32'(k * 10);
            tick();
        end
        settle();
        rd_s("sat_bin0", 3'd0, 3);
        rd_s("sat_bin7", 3'd7, 3);
        rd_s("sat_bin0_again", 3'd0, 3);
        rd_s("sat_bin1", 3'd1, 0);
        tick(); tick();

        chk("drain_main", exp_q.size(), 0);
        chk("drain_sat", exp_s.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inc_class_histogram.md
# inc_class_histogram

Downstream monitor for the decode-and-accumulate stage. It takes that stage's 32-bit running accumulator as a valid-qualified stream and computes each step's increment against the previous valid sample. It classifies each increment into one of the decode weight classes and keeps saturating per-class occurrence counters. Counters are read back over a registered request/response port, and a sticky error flag is raised on any increment that is not a legal weight.

## Interface
- CNT_W, 16, width of each histogram counter (2..32)
- CLEAR_ON_READ, 1, 1 = the counter that was read is cleared by the read; 0 = reads are non-destructive
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is a new accumulator sample this cycle
- in_data  input  32  running accumulator value
- rd_req  input  1  read request, single-cycle pulse or held high
- rd_idx  input  3  bin to read (0..7)
- rd_valid  output  1  rd_data valid this cycle
- rd_data  output  CNT_W  counter value returned for the request
- err  output  1  sticky flag: an illegal increment was seen

## Operation
- Bins:
  - 0 = delta 10
  - 1 = delta 20
  - 2 = delta 30
  - 3 = delta 40
  - 4 = delta 50
  - 5 = delta 0
  - 6 = any other delta (illegal)
  - 7 = total classified samples
- Every classified sample increments bin 7 and exactly one of bins 0..6.
- Delta = in_data − prev, modulo 2^32. A wrap such as 0xFFFFFFFA → 0x00000004 gives delta 10 (bin 0).
- prev and prev_ok hold the last valid sample and whether one exists.
  - When in_valid && !prev_ok: store prev and set prev_ok. No classification and no bin 7 count.
  - When in_valid && prev_ok: classify, then store prev.
  - When !in_valid: prev and prev_ok are unchanged. Gaps are transparent, and the delta is always taken against the last valid sample.
- Pipeline:
  - Stage 1 registers the class one-hot (7 bits) and a class-valid bit.
  - Stage 2 updates the counters.
- Counters saturate at 2^CNT_W − 1 and never wrap, including bin 7.
- err is set on the same edge that bin 6 is updated. Only rst clears it; reads never clear it.
- Reads:
  - rd_req at cycle T returns rd_data = counter[rd_idx] as it stands during cycle T, i.e. before any update committing at edge T+1.
  - rd_valid is a registered copy of rd_req. Back-to-back requests give one response per cycle.
  - With CLEAR_ON_READ=1, the read counter is cleared at edge T+1.
- Read of bin b coinciding with a stage-2 increment of bin b:
  - CLEAR_ON_READ=1: rd_data is the old value and the counter becomes 1. No event is lost.
  - CLEAR_ON_READ=0: rd_data is the old value and the counter becomes old+1, saturated.
- The same rules apply to bin 7 when it is read during any classified update.

## Timing
- Reset values after a cycle with rst high:
  - prev = 0 and prev_ok = 0
  - Stage-1 class-valid = 0
  - All counters = 0
  - rd_valid = 0, rd_data = 0, err = 0
- rst is sampled at clk. It overrides all inputs that cycle, including in_valid and rd_req.
- A read pending at the reset edge produces no response.
- A stage-1 class in flight at the reset edge is discarded.
- Latency: a sample accepted at edge N, with prev_ok already set, is registered in stage 1 at edge N+1 and visible in its counter after edge N+2. A read requested in the cycle after edge N+2 returns it.
- err rises after edge N+2 for an illegal sample accepted at edge N.
- Read latency is 1 cycle: rd_req at cycle T gives rd_valid=1 and rd_data in cycle T+1.
- rd_data holds its last value while rd_valid=0.
- Throughput is one sample per cycle and one read per cycle, concurrently.

## Test plan
- Legal sequence: after reset, feed in_valid=1 with 0, 50, 90, 120, 140, 150, 150. Then read bins 0..7 back-to-back, with CLEAR_ON_READ=1. Required bins:
  - bin 0 = 1 (delta 10)
  - bin 1 = 1 (delta 20)
  - bin 2 = 1 (delta 30)
  - bin 3 = 1 (delta 40)
  - bin 4 = 1 (delta 50)
  - bin 5 = 1 (delta 0)
  - bin 6 = 0 and bin 7 = 6
  - err = 0
  - An immediate re-read of all bins returns 0.
- Gaps and wrap: feed 0xFFFFFFFA, then in_valid=0 for 3 cycles, then 0x00000004. Required: bin 0 = 1, bin 7 = 1.
- Illegal increment: feed 100 then 107. Required: bin 6 = 1, err = 1 two edges after the second sample. err stays 1 after a read of bin 6 and after 10 further idle cycles. A rst pulse clears it.
- Read/update collision, CLEAR_ON_READ=1, with bin 0 preloaded to 3: hold rd_req with rd_idx=0 in the same cycle a delta-10 sample is in stage 2. Required: rd_data = 3, and the next read returns 1.
- Saturation with CNT_W=2: feed 5 samples at 0, 10, 20, …, 40. Required: bin 0 = 3, bin 7 = 3.
- Reset mid-operation: assert rst in the cycle after a sample is accepted, with rd_req high. Required:
  - rd_valid stays 0 and all bins read 0.
  - The next sample after reset only primes prev, so bin 7 stays 0.
